// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, per-lane NOP kill,
// synchronous flush and a saturating stall-cycle counter.
module if_id_skid_reg #(
    parameter int              LANES = 4,
    parameter int              IW    = 22,
    parameter int              PCW   = 10,
    parameter logic [IW-1:0]   NOP   = 22'b00_00000_00000_00000_01100,
    parameter int              STW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_valid,
    output logic                  f_ready,
    input  logic [LANES*IW-1:0]   f_bundle,
    input  logic [PCW-1:0]        f_pc_plus,
    input  logic [LANES-1:0]      lane_kill,
    input  logic                  flush,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [LANES*IW-1:0]   d_bundle,
    output logic [PCW-1:0]        d_pc_next,
    output logic [STW-1:0]        stall_cycles
);

    logic                 main_valid_reg, main_valid_next;
    logic [LANES*IW-1:0]  main_bundle_reg, main_bundle_next;
    logic [PCW-1:0]       main_pc_reg, main_pc_next;
    logic                 skid_valid_reg, skid_valid_next;
    logic [LANES*IW-1:0]  skid_bundle_reg, skid_bundle_next;
    logic [PCW-1:0]       skid_pc_reg, skid_pc_next;
    logic                 f_ready_reg, f_ready_next;
    logic [STW-1:0]       stall_reg, stall_next;

    logic                 accept;
    logic                 drain;
    logic [LANES*IW-1:0]  in_bundle;

    assign accept = f_valid & f_ready_reg;
    assign drain  = main_valid_reg & d_ready;

    // Killed lanes are replaced at capture; outputs show NOP whenever main is empty.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign in_bundle[gi*IW +: IW] = lane_kill[gi] ? NOP : f_bundle[gi*IW +: IW];
            assign d_bundle[gi*IW +: IW]  = main_valid_reg ? main_bundle_reg[gi*IW +: IW] : NOP;
        end
    endgenerate

    assign d_valid      = main_valid_reg;
    assign d_pc_next    = main_valid_reg ? main_pc_reg : '0;
    assign f_ready      = f_ready_reg;
    assign stall_cycles = stall_reg;

    always_comb begin
        main_valid_next  = main_valid_reg;
        main_bundle_next = main_bundle_reg;
        main_pc_next     = main_pc_reg;
        skid_valid_next  = skid_valid_reg;
        skid_bundle_next = skid_bundle_reg;
        skid_pc_next     = skid_pc_reg;

        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid_reg) begin
            // FULL: f_ready is low, so only a drain can move data
            if (drain) begin
                main_bundle_next = skid_bundle_reg;
                main_pc_next     = skid_pc_reg;
                skid_valid_next  = 1'b0;
            end
        end else if (main_valid_reg) begin
            if (accept && drain) begin
                main_bundle_next = in_bundle;
                main_pc_next     = f_pc_plus;
            end else if (accept) begin
                skid_bundle_next = in_bundle;
                skid_pc_next     = f_pc_plus;
                skid_valid_next  = 1'b1;
            end else if (drain) begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            main_bundle_next = in_bundle;
            main_pc_next     = f_pc_plus;
            main_valid_next  = 1'b1;
        end

        f_ready_next = ~skid_valid_next;

        stall_next = stall_reg;
        if (main_valid_reg && !d_ready && stall_reg != {STW{1'b1}}) begin
            stall_next = stall_reg + STW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            f_ready_reg    <= 1'b1;
            stall_reg      <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            f_ready_reg    <= f_ready_next;
            stall_reg      <= stall_next;
        end
        main_bundle_reg <= main_bundle_next;
        main_pc_reg     <= main_pc_next;
        skid_bundle_reg <= skid_bundle_next;
        skid_pc_reg     <= skid_pc_next;
    end

endmodule
